// File: rtl/user_proj_counter.sv
// Wishbone-slave BITS-wide up/down counter with compare/reload and a sticky MATCH flag.
// Define USER_PROJ_COUNTER_IRQ_EN to enable CTRL.IE and the registered irq[0] output.
module user_proj_counter #(
    parameter int          BITS     = 32,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb,
    output logic [2:0]  irq
);

    logic            r_ack;
    logic [31:0]     r_dat;
    logic            r_en, r_dir, r_reload, r_match;
    logic [BITS-1:0] r_count, r_cmp;

    logic            w_win, w_acc, w_wr;
    logic [5:0]      w_off;
    logic            w_ie;
    logic            w_hit;
    logic [31:0]     w_cnt_ext, w_cmp_ext, w_cnt_wr, w_cmp_wr, w_rdata;
    logic            w_unused_ok;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  sel);
        logic [31:0] v;
        v = old_v;
        for (int b = 0; b < 4; b++)
            if (sel[b]) v[8*b +: 8] = new_v[8*b +: 8];
        return v;
    endfunction

    assign w_win = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    // Gating on ~r_ack makes every transfer exactly one ack pulse, two cycles minimum.
    assign w_acc = wbs_cyc_i & wbs_stb_i & w_win & ~r_ack;
    assign w_wr  = w_acc & wbs_we_i;
    assign w_off = wbs_adr_i[7:2];
    assign w_hit = r_en & (r_count == r_cmp);

    always_comb begin
        w_cnt_ext = '0;
        w_cmp_ext = '0;
        w_cnt_ext[BITS-1:0] = r_count;
        w_cmp_ext[BITS-1:0] = r_cmp;
    end

    assign w_cnt_wr = f_merge(w_cnt_ext, wbs_dat_i, wbs_sel_i);
    assign w_cmp_wr = f_merge(w_cmp_ext, wbs_dat_i, wbs_sel_i);

    always_comb begin
        w_rdata = '0;
        case (w_off)
            6'd0:    w_rdata = {28'd0, w_ie, r_reload, r_dir, r_en};
            6'd1:    w_rdata = w_cnt_ext;
            6'd2:    w_rdata = w_cmp_ext;
            6'd3:    w_rdata = {31'd0, r_match};
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_en     <= 1'b0;
            r_dir    <= 1'b0;
            r_reload <= 1'b0;
            r_match  <= 1'b0;
            r_count  <= '0;
            r_cmp    <= '1;
        end else begin
            r_ack <= w_acc;
            r_dat <= (w_acc & ~wbs_we_i) ? w_rdata : 32'd0;

            if (w_wr && w_off == 6'd0 && wbs_sel_i[0]) begin
                r_en     <= wbs_dat_i[0];
                r_dir    <= wbs_dat_i[1];
                r_reload <= wbs_dat_i[2];
            end

            if (w_wr && w_off == 6'd2)
                r_cmp <= w_cmp_wr[BITS-1:0];

            // A firmware load beats both the step and the reload.
            if (w_wr && w_off == 6'd1)
                r_count <= w_cnt_wr[BITS-1:0];
            else if (r_en) begin
                if (w_hit && r_reload)
                    r_count <= r_dir ? r_cmp : '0;
                else
                    r_count <= r_dir ? r_count - 1'b1 : r_count + 1'b1;
            end

            // A match in the same cycle as the clear keeps the flag set.
            if (w_hit)
                r_match <= 1'b1;
            else if (w_wr && w_off == 6'd3 && wbs_sel_i[0] && wbs_dat_i[0])
                r_match <= 1'b0;
        end
    end

`ifdef USER_PROJ_COUNTER_IRQ_EN
    logic r_ie, r_irq;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ie  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (w_wr && w_off == 6'd0 && wbs_sel_i[0])
                r_ie <= wbs_dat_i[3];
            r_irq <= r_match & r_ie;
        end
    end

    assign w_ie = r_ie;
    assign irq  = {2'b00, r_irq};
`else
    assign w_ie = 1'b0;
    assign irq  = 3'b000;
`endif

    assign wbs_ack_o   = r_ack;
    assign wbs_dat_o   = r_dat;
    assign io_out      = {22'd0, r_count[15:0]};
    assign io_oeb      = {{22{1'b1}}, 16'd0};
    assign w_unused_ok = ^{wbs_adr_i[1:0], BASE_ADR[7:0], w_cnt_wr, w_cmp_wr};

endmodule
